alu_packet_engine: RTL and testbench
====================================

# alu_packet_engine

Byte-stream ALU command engine between the UART receiver and the UART transmitter. It consumes received bytes over a valid/ready handshake and parses them into packets. For each packet it either echoes the payload or computes a 32-bit add/multiply reduction over the operands, then streams the response bytes to the transmitter. Malformed packets are discarded byte-exact, so the stream never loses framing.

## Interface
- No parameters.
- clk_i  in  1  system clock, 32.256 MHz on the board.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- rx_data_i  in  8  received byte from the UART RX.
- rx_valid_i  in  1  rx_data_i holds a byte.
- rx_ready_o  out  1  engine accepts rx_data_i this cycle.
- tx_data_o  out  8  response byte to the UART TX.
- tx_valid_o  out  1  tx_data_o is valid.
- tx_ready_i  in  1  TX accepts tx_data_o this cycle.
- busy_o  out  1  high in every state except S_OPC.
- err_o  out  1  one-cycle pulse when a packet is rejected.

## Operation
- Packet layout: byte0 opcode; byte1 reserved (ignored); bytes2-3 LEN, 16-bit little-endian, total packet bytes including the 4-byte header; then the payload of LEN-4 bytes.
- Opcodes:
  - 0xEC echo.
  - 0x8A add32.
  - 0x9B mul32 (only with ALU_MUL_EN).
- Arithmetic payload is N 32-bit LE operands, N = (LE­N-4)/4 ≥ 1.
- States:
  - S_OPC, S_RSV, S_LEN0, S_LEN1: header capture, one byte each.
  - S_OPND: shift operand bytes into a 32-bit register. After each 4th byte: the first operand loads acc; later operands apply acc = acc+opnd or acc = acc*opnd, both mod 2^32. After the last operand go to S_RESP.
  - S_RESP: emit acc as 4 bytes, LSB first, then go to S_OPC.
  - S_ECHO: pass LEN-4 payload bytes straight through: tx_data_o = rx_data_i, tx_valid_o = rx_valid_i, rx_ready_o = tx_ready_i. Go to S_OPC after the last byte. If LEN = 4, go straight to S_OPC; nothing is sent.
  - S_DRAIN: accept and discard the remaining LEN-4 payload bytes, then go to S_OPC.
- Validation, decided on accepting the LEN1 byte:
  - Unknown opcode goes to S_DRAIN.
  - Arithmetic with LEN < 8 or LEN[1:0] ≠ 0 goes to S_DRAIN.
  - LEN < 4, any opcode: err_o pulses and the engine returns to S_OPC; no drain.
  - err_o pulses on the cycle after the LEN1 byte is accepted, for every rejection.
- Remaining-byte counter is 16 bits and decrements on each accepted payload byte; the final byte is the one accepted when the count is 1.

## Timing
- Reset values: rx_ready_o=0, tx_valid_o=0, tx_data_o=0x00, busy_o=0, err_o=0. State is S_OPC; acc and counters are 0.
- First cycle after reset release: rx_ready_o=1.
- rx_ready_o:
  - 1 in header, S_OPND and S_DRAIN.
  - 0 in S_RESP.
  - Equals tx_ready_i in S_ECHO.
- A byte transfers on clock edges with valid & ready; throughput is one byte per cycle.
- Arithmetic latency: S_RESP is entered the cycle after the last operand byte is accepted. tx_valid_o rises that cycle with acc[7:0] and stays high through all 4 bytes, advancing on each tx_valid_o & tx_ready_i. tx_data_o is stable while tx_ready_i=0.
- The next packet's opcode is accepted no earlier than the cycle after the 4th response byte transfers.
- The multiply result is registered in the same cycle the operand completes; no extra pipeline stage.
- Reset mid-packet or mid-response: immediate abort, outputs take reset values, and no partial response resumes.

## Configuration
- ALU_MUL_EN defined: opcode 0x9B performs mul32 and a 32x32 multiplier is instantiated.
- ALU_MUL_EN undefined: 0x9B is an unknown opcode (err_o pulse, payload drained), and no multiplier logic is present.

## Test plan
- Add: 8A 00 0C 00 01 00 00 00 02 00 00 00 -> tx 03 00 00 00; err_o stays 0.
- Add wrap: 8A 00 0C 00 FF FF FF FF 02 00 00 00 -> tx 01 00 00 00.
- Multiply:
  - Stimulus 9B 00 0C 00 00 00 01 00 03 00 01 00.
  - With ALU_MUL_EN -> tx 00 00 03 00.
  - Without ALU_MUL_EN -> one err_o pulse, 8 bytes drained, no tx.
- Echo with backpressure: EC 00 07 00 41 42 43, tx_ready_i toggling every cycle -> tx 41 42 43 in order, no byte lost or duplicated.
- Bad length: 8A 00 0A 00 + 6 bytes -> one err_o pulse, 6 bytes consumed, no tx. A following valid add packet responds correctly.
- Reset asserted after 2nd response byte -> tx_valid_o=0 immediately. A new add packet after release responds with its own 4 bytes only.

Source files
------------

// File: rtl/alu_packet_engine.sv
// Byte-stream ALU command engine: parses packets, echoes or reduces 32-bit operands.
// Define ALU_MUL_EN to enable opcode 0x9B (mul32) and its 32x32 multiplier.
module alu_packet_engine (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        StOpc,
        StRsv,
        StLen0,
        StLen1,
        StOpnd,
        StResp,
        StEcho,
        StDrain
    } state_e;

    localparam logic [7:0] OpEcho = 8'hEC;
    localparam logic [7:0] OpAdd  = 8'h8A;
`ifdef ALU_MUL_EN
    localparam logic [7:0] OpMul  = 8'h9B;
`endif

    state_e      state_q;
    logic [7:0]  opc_q;
    logic [7:0]  len_lo_q;
    logic [15:0] cnt_q;
    logic [23:0] opnd_q;
    logic [31:0] acc_q;
    logic [1:0]  byte_idx_q;
    logic        first_q;
    logic        err_q;
    logic        live_q;
`ifdef ALU_MUL_EN
    logic        is_mul_q;
    logic [31:0] mul_res;
`endif

    logic        rx_fire;
    logic        tx_fire;
    logic [15:0] len_full;
    logic [15:0] len_pay;
    logic        len_short;
    logic        arith_bad;
    logic        op_arith;
    logic [31:0] opnd_full;
    logic [31:0] alu_res;
    logic [31:0] acc_shift;

    assign rx_fire   = rx_valid_i & rx_ready_o;
    assign tx_fire   = tx_valid_o & tx_ready_i;
    assign len_full  = {rx_data_i, len_lo_q};
    assign len_pay   = len_full - 16'd4;
    assign len_short = len_full < 16'd4;
    assign arith_bad = (len_full < 16'd8) || (len_full[1:0] != 2'b00);
    assign opnd_full = {rx_data_i, opnd_q};
    assign acc_shift = acc_q >> {byte_idx_q, 3'b000};
    assign busy_o    = state_q != StOpc;
    assign err_o     = err_q;

`ifdef ALU_MUL_EN
    assign op_arith = (opc_q == OpAdd) || (opc_q == OpMul);
    assign mul_res  = acc_q * opnd_full;
    assign alu_res  = is_mul_q ? mul_res : acc_q + opnd_full;
`else
    assign op_arith = opc_q == OpAdd;
    assign alu_res  = acc_q + opnd_full;
`endif

    // live_q keeps the handshake quiet until the first clock after reset release.
    always_comb begin
        rx_ready_o = 1'b0;
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        if (live_q) begin
            unique case (state_q)
                StOpc, StRsv, StLen0, StLen1, StOpnd, StDrain: rx_ready_o = 1'b1;
                StResp: begin
                    tx_valid_o = 1'b1;
                    tx_data_o  = acc_shift[7:0];
                end
                StEcho: begin
                    rx_ready_o = tx_ready_i;
                    tx_valid_o = rx_valid_i;
                    tx_data_o  = rx_data_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StOpc;
            opc_q      <= 8'h00;
            len_lo_q   <= 8'h00;
            cnt_q      <= 16'h0000;
            opnd_q     <= 24'h000000;
            acc_q      <= 32'h00000000;
            byte_idx_q <= 2'd0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
            live_q     <= 1'b0;
`ifdef ALU_MUL_EN
            is_mul_q   <= 1'b0;
`endif
        end else begin
            live_q <= 1'b1;
            err_q  <= 1'b0;
            unique case (state_q)
                StOpc: begin
                    if (rx_fire) begin
                        opc_q   <= rx_data_i;
                        state_q <= StRsv;
                    end
                end
                StRsv: begin
                    if (rx_fire) state_q <= StLen0;
                end
                StLen0: begin
                    if (rx_fire) begin
                        len_lo_q <= rx_data_i;
                        state_q  <= StLen1;
                    end
                end
                StLen1: begin
                    if (rx_fire) begin
                        cnt_q      <= len_pay;
                        byte_idx_q <= 2'd0;
                        first_q    <= 1'b1;
`ifdef ALU_MUL_EN
                        is_mul_q   <= opc_q == OpMul;
`endif
                        // A header shorter than itself cannot be drained: drop it outright.
                        if (len_short) begin
                            err_q   <= 1'b1;
                            cnt_q   <= 16'h0000;
                            state_q <= StOpc;
                        end else if (opc_q == OpEcho) begin
                            state_q <= (len_pay == 16'd0) ? StOpc : StEcho;
                        end else if (op_arith && !arith_bad) begin
                            state_q <= StOpnd;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= (len_pay == 16'd0) ? StOpc : StDrain;
                        end
                    end
                end
                StOpnd: begin
                    if (rx_fire) begin
                        cnt_q      <= cnt_q - 16'd1;
                        opnd_q     <= {rx_data_i, opnd_q[23:8]};
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            acc_q   <= first_q ? opnd_full : alu_res;
                            first_q <= 1'b0;
                        end
                        if (cnt_q == 16'd1) state_q <= StResp;
                    end
                end
                StResp: begin
                    if (tx_fire) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) state_q <= StOpc;
                    end
                end
                StEcho, StDrain: begin
                    if (rx_fire) begin
                        cnt_q <= cnt_q - 16'd1;
                        if (cnt_q == 16'd1) state_q <= StOpc;
                    end
                end
                default: state_q <= StOpc;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_packet_engine.sv
// Directed self-checking bench for alu_packet_engine (mul case follows ALU_MUL_EN).
`timescale 1ns/1ps
module tb_alu_packet_engine;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_valid_i = 1'b0;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i = 1'b1;
    logic       busy_o;
    logic       err_o;

    int         checks = 0;
    int         errors = 0;
    int         err_seen = 0;
    bit         toggle_en = 1'b0;
    logic [7:0] tx_q[$];

    alu_packet_engine dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
        if (err_o) err_seen++;
    end

    always @(negedge clk_i) tx_ready_i = toggle_en ? ~tx_ready_i : 1'b1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one byte and return just after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        int waits = 0;
        @(negedge clk_i);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        #1;
        while (!rx_ready_o && waits < 200) begin
            @(negedge clk_i);
            #1;
            waits++;
        end
        if (!rx_ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: rx_ready_o=%0b required 1", rx_ready_o);
        end else begin
            @(posedge clk_i);
        end
    endtask

    task automatic send_bytes(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
    endtask

    task automatic rx_idle();
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        int cyc = 0;
        while (tx_q.size() < n && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
        end
        repeat (6) @(negedge clk_i);
    endtask

    function automatic logic [31:0] tx_word();
        if (tx_q.size() != 4) return 32'hxxxxxxxx;
        return {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
    endfunction

    task automatic test_reset();
        @(negedge clk_i);
        checks++;
        if ({rx_ready_o, tx_valid_o, busy_o, err_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/vld/busy/err=%b required 0000",
                     {rx_ready_o, tx_valid_o, busy_o, err_o});
        end
        checks++;
        if (tx_data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: tx_data_o=%h required 00", tx_data_o);
        end
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if (rx_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: rx_ready_o=%b busy_o=%b required 1 0", rx_ready_o, busy_o);
        end
    endtask

    task automatic test_add();
        int e0 = err_seen;
        tx_q.delete();
        send_bytes(128'h8A000C00_01000000_02000000, 12);
        #1;
        checks++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h03) begin
            errors++;
            $display("FAIL add_latency: tx_valid_o=%b tx_data_o=%h required 1 03",
                     tx_valid_o, tx_data_o);
        end
        rx_idle();
        wait_tx(4);
        checks++;
        if (tx_word() !== 32'h00000003) begin
            errors++;
            $display("FAIL add_result: got %h (%0d bytes) required 00000003", tx_word(), tx_q.size());
        end
        checks++;
        if (err_seen - e0 != 0) begin
            errors++;
            $display("FAIL add_err: err pulses=%0d required 0", err_seen - e0);
        end
    endtask

    task automatic test_add_wrap();
        tx_q.delete();
        send_bytes(128'h8A000C00_FFFFFFFF_02000000, 12);
        rx_idle();
        wait_tx(4);
        checks++;
        if (tx_word() !== 32'h00000001) begin
            errors++;
            $display("FAIL add_wrap: got %h required 00000001", tx_word());
        end
    endtask

    task automatic test_mul();
        int e0 = err_seen;
        tx_q.delete();
`ifdef ALU_MUL_EN
        send_bytes(128'h9B000C00_00000100_03000100, 12);
        rx_idle();
        wait_tx(4);
        checks++;
        if (tx_word() !== 32'h00030000) begin
            errors++;
            $display("FAIL mul_result: got %h required 00030000", tx_word());
        end
        checks++;
        if (err_seen - e0 != 0) begin
            errors++;
            $display("FAIL mul_err: err pulses=%0d required 0", err_seen - e0);
        end
`else
        send_bytes(128'h9B000C00, 4);
        #1;
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mul_reject: err_o=%b busy_o=%b required 1 1", err_o, busy_o);
        end
        send_bytes(128'h00000100_03000100, 8);
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mul_drain: busy_o=%b required 0", busy_o);
        end
        rx_idle();
        repeat (8) @(negedge clk_i);
        checks++;
        if (tx_q.size() != 0 || err_seen - e0 != 1) begin
            errors++;
            $display("FAIL mul_silent: tx bytes=%0d err pulses=%0d required 0 1",
                     tx_q.size(), err_seen - e0);
        end
`endif
    endtask

    task automatic test_echo_backpressure();
        tx_q.delete();
        toggle_en = 1'b1;
        send_bytes(128'hEC000700_414243, 7);
        rx_idle();
        toggle_en = 1'b0;
        wait_tx(3);
        checks++;
        if (tx_q.size() != 3) begin
            errors++;
            $display("FAIL echo_count: got %0d bytes required 3", tx_q.size());
        end else begin
            checks++;
            if ({tx_q[0], tx_q[1], tx_q[2]} !== 24'h414243) begin
                errors++;
                $display("FAIL echo_data: got %h%h%h required 414243", tx_q[0], tx_q[1], tx_q[2]);
            end
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL echo_done: busy_o=%b required 0", busy_o);
        end
    endtask

    task automatic test_short_len();
        tx_q.delete();
        send_bytes(128'h8A000200, 4);
        #1;
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL len_lt4: err_o=%b busy_o=%b required 1 0", err_o, busy_o);
        end
        send_bytes(128'hEC000400, 4);
        #1;
        checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL echo_len4: err_o=%b busy_o=%b required 0 0", err_o, busy_o);
        end
        rx_idle();
        repeat (6) @(negedge clk_i);
        checks++;
        if (tx_q.size() != 0) begin
            errors++;
            $display("FAIL short_silent: tx bytes=%0d required 0", tx_q.size());
        end
    endtask

    task automatic test_bad_length();
        int e0 = err_seen;
        tx_q.delete();
        send_bytes(128'h8A000A00, 4);
        #1;
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL badlen_err: err_o=%b busy_o=%b required 1 1", err_o, busy_o);
        end
        send_bytes(128'h112233445566, 6);
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL badlen_drain: busy_o=%b required 0", busy_o);
        end
        send_bytes(128'h8A001000_05000000_06000000_07000000, 16);
        rx_idle();
        wait_tx(4);
        checks++;
        if (tx_word() !== 32'h00000012) begin
            errors++;
            $display("FAIL badlen_next: got %h required 00000012", tx_word());
        end
        checks++;
        if (err_seen - e0 != 1) begin
            errors++;
            $display("FAIL badlen_pulses: err pulses=%0d required 1", err_seen - e0);
        end
    endtask

    task automatic test_reset_mid_response();
        int cyc = 0;
        tx_q.delete();
        send_bytes(128'h8A000C00_10000000_20000000, 12);
        rx_idle();
        while (tx_q.size() < 2 && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({tx_valid_o, rx_ready_o, busy_o} !== 3'b000 || tx_data_o !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: vld/rdy/busy=%b data=%h required 000 00",
                     {tx_valid_o, rx_ready_o, busy_o}, tx_data_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tx_q.delete();
        send_bytes(128'h8A000800_2A000000, 8);
        rx_idle();
        wait_tx(4);
        checks++;
        if (tx_word() !== 32'h0000002A) begin
            errors++;
            $display("FAIL after_reset: got %h (%0d bytes) required 0000002a",
                     tx_word(), tx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_wrap();
        test_mul();
        test_echo_backpressure();
        test_short_len();
        test_bad_length();
        test_reset_mid_response();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
